// File: rtl/multi_filter_mul_pipe_hs.sv
// -----------------------------------------------------------------------------
// multi_filter_mul_pipe_hs
//
// Handshaked, pipelined multiplier for the multi_filter datapath.
// Each operand is widened by one bit (sign- or zero-extended per SIGNEDx).
// The extended operands are multiplied as signed values. The product is
// rounded half-up by SHIFT bits and saturated to DOUT_WIDTH. Every stage
// carries its own valid bit, so empty stages (bubbles) keep filling while
// the stages downstream of them are stalled.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   ce         global clock enable; 0 freezes every register including valids
//   in_valid   input beat valid
//   in_ready   block accepts a beat this cycle (combinational ready chain)
//   din0       operand A, DIN0_WIDTH bits
//   din1       operand B, DIN1_WIDTH bits
//   out_valid  dout/sat carry a beat
//   out_ready  downstream accepts the beat on dout
//   dout       rounded, saturated product, DOUT_WIDTH bits
//   sat        the beat on dout was clipped (qualified by out_valid)
// -----------------------------------------------------------------------------
module multi_filter_mul_pipe_hs #(
  parameter int DIN0_WIDTH = 31,
  parameter int DIN1_WIDTH = 33,
  parameter int DOUT_WIDTH = 32,
  parameter int NUM_STAGE  = 2,
  parameter int SIGNED0    = 0,
  parameter int SIGNED1    = 0,
  parameter int SHIFT      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  sat
);

  // Working width: the P-bit product plus one guard bit, so the rounding
  // offset can be added without overflow.
  localparam int RW         = DIN0_WIDTH + DIN1_WIDTH + 2;
  localparam bit SIGNED_OUT = (SIGNED0 != 0) || (SIGNED1 != 0);

  // ---------------------------------------------------------------------------
  // Operand extension and multiply
  // ---------------------------------------------------------------------------
  logic signed [DIN0_WIDTH:0] a_ext;
  logic signed [DIN1_WIDTH:0] b_ext;
  logic signed [RW-1:0]       a_wide;
  logic signed [RW-1:0]       b_wide;
  logic signed [RW-1:0]       in_prod;

  // The extension bit is the operand MSB in signed mode and 0 otherwise.
  assign a_ext   = {(SIGNED0 != 0) & din0[DIN0_WIDTH-1], din0};
  assign b_ext   = {(SIGNED1 != 0) & din1[DIN1_WIDTH-1], din1};
  assign a_wide  = RW'(a_ext);
  assign b_wide  = RW'(b_ext);
  // The true product always fits in RW bits, so the truncated multiply is exact.
  assign in_prod = a_wide * b_wide;

  // ---------------------------------------------------------------------------
  // Handshake: per-stage valid bits and combinational ready chain
  // ---------------------------------------------------------------------------
  logic [NUM_STAGE-1:0] valid_reg;
  logic [NUM_STAGE-1:0] up_valid;
  logic [NUM_STAGE-1:0] stage_ready;
  logic [NUM_STAGE-1:0] stage_load;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign up_valid[gi] = in_valid;
      end else begin : g_rest
        assign up_valid[gi] = valid_reg[gi-1];
      end
      assign stage_load[gi] = ce & stage_ready[gi];
    end
  endgenerate

  // A stage can take new data when it is empty or its contents move on this
  // cycle. The chain runs from the output back to the input, so a full pipe
  // with out_ready=1 still accepts a beat.
  always_comb begin
    stage_ready = '0;
    stage_ready[NUM_STAGE-1] = ~valid_reg[NUM_STAGE-1] | out_ready;
    for (int i = NUM_STAGE - 2; i >= 0; i--) begin
      stage_ready[i] = ~valid_reg[i] | stage_ready[i+1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        if (stage_load[i]) begin
          valid_reg[i] <= up_valid[i];
        end
      end
    end
  end

  assign in_ready  = stage_ready[0] & ce;
  assign out_valid = valid_reg[NUM_STAGE-1];

  // ---------------------------------------------------------------------------
  // Raw-product pipeline (stage 1 .. N-1)
  // ---------------------------------------------------------------------------
  logic signed [RW-1:0] src_prod;

  generate
    if (NUM_STAGE == 1) begin : g_single
      assign src_prod = in_prod;
    end else begin : g_prod
      logic signed [RW-1:0] prod_reg [NUM_STAGE-1];

      // Data registers only load with a real beat; bubbles leave them alone.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < NUM_STAGE - 1; i++) begin
            prod_reg[i] <= '0;
          end
        end else begin
          if (stage_load[0] & in_valid) begin
            prod_reg[0] <= in_prod;
          end
          for (int i = 1; i < NUM_STAGE - 1; i++) begin
            if (stage_load[i] & up_valid[i]) begin
              prod_reg[i] <= prod_reg[i-1];
            end
          end
        end
      end

      assign src_prod = prod_reg[NUM_STAGE-2];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round half-up (ties toward +inf) with arithmetic right shift
  // ---------------------------------------------------------------------------
  logic signed [RW-1:0] r_val;

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
      assign r_val = (src_prod + HALF) >>> SHIFT;
    end else begin : g_no_round
      assign r_val = src_prod;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Saturation to DOUT_WIDTH
  // ---------------------------------------------------------------------------
  logic [DOUT_WIDTH-1:0] dout_next;
  logic                  sat_next;

  generate
    if (SIGNED_OUT && (DOUT_WIDTH < RW)) begin : g_sat_signed
      // In range only when every bit from DOUT_WIDTH-1 upward equals the sign.
      logic [RW-DOUT_WIDTH:0] hi_bits;
      assign hi_bits = r_val[RW-1:DOUT_WIDTH-1];
      always_comb begin
        sat_next  = ~((&hi_bits) | ~(|hi_bits));
        dout_next = r_val[DOUT_WIDTH-1:0];
        if (sat_next) begin
          dout_next = r_val[RW-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                  : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        end
      end
    end else if (SIGNED_OUT) begin : g_wide_signed
      assign dout_next = DOUT_WIDTH'(r_val);
      assign sat_next  = 1'b0;
    end else if (DOUT_WIDTH < RW) begin : g_sat_unsigned
      logic [RW-DOUT_WIDTH-1:0] hi_bits;
      assign hi_bits = r_val[RW-1:DOUT_WIDTH];
      always_comb begin
        sat_next  = |hi_bits;
        dout_next = r_val[DOUT_WIDTH-1:0];
        if (r_val[RW-1]) begin
          dout_next = '0;
        end else if (|hi_bits) begin
          dout_next = '1;
        end
      end
    end else begin : g_wide_unsigned
      assign sat_next  = r_val[RW-1];
      assign dout_next = r_val[RW-1] ? '0 : DOUT_WIDTH'($unsigned(r_val));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic [DOUT_WIDTH-1:0] dout_reg;
  logic                  sat_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_reg <= '0;
      sat_reg  <= 1'b0;
    end else if (stage_load[NUM_STAGE-1] & up_valid[NUM_STAGE-1]) begin
      dout_reg <= dout_next;
      sat_reg  <= sat_next;
    end
  end

  assign dout = dout_reg;
  assign sat  = sat_reg;

endmodule
